// File: rtl/pb_conditioner.sv
// pb_conditioner: synchronises, debounces and edge-detects the four game
// pushbuttons (yellow/red/blue/green). It produces one registered pulse per
// accepted press, plus a priority-encoded press code and the debounced levels.
// Optional build macro PB_LOCKOUT_EN: when it is defined, a press made while
// another button is held is rejected. The same happens to presses accepted
// together. All pulses stay suppressed until every button has been released.
module pb_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pb_yellow,
    input  logic       pb_red,
    input  logic       pb_blue,
    input  logic       pb_green,
    output logic       yellow,
    output logic       red,
    output logic       blue,
    output logic       green,
    output logic       btn_valid,
    output logic [1:0] btn_code,
    output logic [3:0] held
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Lowest set bit wins: yellow has the highest priority.
    function automatic logic [1:0] encode_first(input logic [3:0] v);
        logic [1:0] code;
        if (v[0]) begin
            code = 2'd0;
        end else if (v[1]) begin
            code = 2'd1;
        end else if (v[2]) begin
            code = 2'd2;
        end else begin
            code = 2'd3;
        end
        return code;
    endfunction

`ifdef PB_LOCKOUT_EN
    // True when two or more buttons are at their accepted pressed level.
    function automatic logic multi_hot(input logic [3:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

    logic lock_r;
    logic lock_next_s;
    logic conflict_s;
`endif

    logic [3:0]                  raw_s;
    logic [SYNC_STAGES-1:0][3:0] sync_r;
    logic [3:0]                  stable_s;
    logic [3:0][CNT_W-1:0]       cnt_r;
    logic [3:0]                  held_r;
    logic [3:0]                  held_d_r;
    logic [3:0]                  rise_s;
    logic [3:0]                  pulse_s;
    logic [3:0]                  pulse_r;
    logic                        valid_r;
    logic [1:0]                  code_r;

    assign raw_s    = {pb_green, pb_blue, pb_red, pb_yellow};
    assign stable_s = sync_r[SYNC_STAGES-1];

    // Metastability synchroniser: shift raw levels through SYNC_STAGES flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= {(SYNC_STAGES * 4){1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw_s};
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES stable samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_r <= 4'b0000;
            cnt_r  <= {(4 * CNT_W){1'b0}};
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (stable_s[i] == held_r[i]) begin
                    cnt_r[i] <= {CNT_W{1'b0}};
                end else if (cnt_r[i] == CNT_LAST) begin
                    held_r[i] <= stable_s[i];
                    cnt_r[i]  <= {CNT_W{1'b0}};
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end
            end
        end
    end

    // Press detection on the accepted level, with optional multi-press lockout.
    always_comb begin
        rise_s = held_r & ~held_d_r;
`ifdef PB_LOCKOUT_EN
        conflict_s = (rise_s != 4'b0000) && multi_hot(held_r);
        if (lock_r || conflict_s) begin
            pulse_s = 4'b0000;
        end else begin
            pulse_s = rise_s;
        end
        if (conflict_s) begin
            lock_next_s = 1'b1;
        end else if (held_r == 4'b0000) begin
            lock_next_s = 1'b0;
        end else begin
            lock_next_s = lock_r;
        end
`else
        pulse_s = rise_s;
`endif
    end

`ifdef PB_LOCKOUT_EN
    // Lock flag: set on a conflicting press, cleared once all buttons are released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_r <= 1'b0;
        end else begin
            lock_r <= lock_next_s;
        end
    end
`endif

    // Output registers: delayed level for edge detection, pulses, valid and code.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_d_r <= 4'b0000;
            pulse_r  <= 4'b0000;
            valid_r  <= 1'b0;
            code_r   <= 2'd0;
        end else begin
            held_d_r <= held_r;
            pulse_r  <= pulse_s;
            valid_r  <= |pulse_s;
            if (|pulse_s) begin
                code_r <= encode_first(pulse_s);
            end else begin
                code_r <= code_r;
            end
        end
    end

    assign yellow    = pulse_r[0];
    assign red       = pulse_r[1];
    assign blue      = pulse_r[2];
    assign green     = pulse_r[3];
    assign btn_valid = valid_r;
    assign btn_code  = code_r;
    assign held      = held_r;

endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner (DEBOUNCE_CYCLES=4, SYNC_STAGES=2). The reference
// model keeps a history of the input samples. A button's level flips once the
// last DEBOUNCE_CYCLES synchronised samples all differ from the accepted level.
module tb_pb_conditioner;

    localparam int DB = 4;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pb_yellow = 1'b0;
    logic       pb_red = 1'b0;
    logic       pb_blue = 1'b0;
    logic       pb_green = 1'b0;
    logic       yellow, red, blue, green, btn_valid;
    logic [1:0] btn_code;
    logic [3:0] held;

    pb_conditioner #(.DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset),
        .pb_yellow(pb_yellow), .pb_red(pb_red), .pb_blue(pb_blue), .pb_green(pb_green),
        .yellow(yellow), .red(red), .blue(blue), .green(green),
        .btn_valid(btn_valid), .btn_code(btn_code), .held(held)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pcount[4];
    int plast[4];
    int base[4];

    // reference model state
    logic [3:0] hist [0:DB];   // hist[0] = input sampled at the previous edge
    logic [3:0] m_held, m_rose, m_pulse;
    logic [1:0] m_code;
`ifdef PB_LOCKOUT_EN
    logic       m_lock;
`endif

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k <= DB; k++) hist[k] = 4'b0000;
        m_held  = 4'b0000;
        m_rose  = 4'b0000;
        m_pulse = 4'b0000;
        m_code  = 2'd0;
`ifdef PB_LOCKOUT_EN
        m_lock  = 1'b0;
`endif
    endtask

    task automatic model_edge(input logic [3:0] r);
        logic [3:0] nh;
        logic       all_diff;
`ifdef PB_LOCKOUT_EN
        logic       conflict;
        conflict = (m_rose != 4'b0000) && ($countones(m_held) >= 2);
        m_pulse  = (m_lock || conflict) ? 4'b0000 : m_rose;
        if (conflict) m_lock = 1'b1;
        else if (m_held == 4'b0000) m_lock = 1'b0;
`else
        m_pulse = m_rose;
`endif
        if (m_pulse != 4'b0000) begin
            for (int i = 3; i >= 0; i--) if (m_pulse[i]) m_code = 2'(i);
        end
        nh = m_held;
        for (int i = 0; i < 4; i++) begin
            all_diff = 1'b1;
            for (int k = 1; k <= DB; k++) if (hist[k][i] == m_held[i]) all_diff = 1'b0;
            if (all_diff) nh[i] = ~m_held[i];
        end
        m_rose = nh & ~m_held;
        m_held = nh;
        for (int k = DB; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = r;
    endtask

    task automatic compare_all();
        logic [3:0] obs;
        obs = {green, blue, red, yellow};
        check_val("pulse", {28'd0, obs}, {28'd0, m_pulse});
        check_val("valid", {31'd0, btn_valid}, {31'd0, |m_pulse});
        check_val("code", {30'd0, btn_code}, {30'd0, m_code});
        check_val("held", {28'd0, held}, {28'd0, m_held});
        for (int i = 0; i < 4; i++) begin
            if (obs[i]) begin
                pcount[i]++;
                plast[i] = cyc;
            end
        end
    endtask

    task automatic step(input logic [3:0] r);
        @(negedge clk);
        {pb_green, pb_blue, pb_red, pb_yellow} = r;
        @(posedge clk);
        if (reset) model_edge(r);
        else model_reset();
        cyc++;
        #1;
        compare_all();
    endtask

    task automatic do_reset(input int n, input logic [3:0] r);
        @(negedge clk);
        reset = 1'b0;
        {pb_green, pb_blue, pb_red, pb_yellow} = r;
        model_reset();
        #1;
        compare_all();
        repeat (n) step(r);
        reset = 1'b1;
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) begin
            base[i]  = pcount[i];
            plast[i] = -100;
        end
    endtask

    function automatic int delta(input int i);
        return pcount[i] - base[i];
    endfunction

    initial begin
        int t0;
        logic [3:0] cur;
        logic [3:0] bounce [5];
        for (int i = 0; i < 4; i++) pcount[i] = 0;
        model_reset();

        // 1: reset with red held, then a single red pulse 7 edges after release
        do_reset(3, 4'b0010);
        snap();
        t0 = cyc;
        repeat (12) step(4'b0010);
        check_val("s1_red_cnt", delta(1), 1);
        check_val("s1_latency", plast[1] - t0, 7);
        repeat (10) step(4'b0000);

        // 2: clean blue press held 20 cycles
        snap();
        t0 = cyc;
        repeat (20) step(4'b0100);
        check_val("s2_blue_cnt", delta(2), 1);
        check_val("s2_latency", plast[2] - t0, 7);
        check_val("s2_held", {28'd0, held}, 32'd4);
        repeat (10) step(4'b0000);

        // 3: bouncing green, then stable
        bounce = '{4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
        snap();
        for (int k = 0; k < 5; k++) step(bounce[k]);
        t0 = cyc;
        repeat (15) step(4'b1000);
        check_val("s3_green_cnt", delta(3), 1);
        check_val("s3_latency", plast[3] - t0, 7);
        repeat (10) step(4'b0000);

        // 4: short yellow glitch is rejected
        snap();
        repeat (3) step(4'b0001);
        repeat (12) step(4'b0000);
        check_val("s4_yellow_cnt", delta(0), 0);

        // 5: yellow and blue together, then release and red alone
        snap();
        repeat (15) step(4'b0101);
`ifdef PB_LOCKOUT_EN
        check_val("s5_yellow_cnt", delta(0), 0);
        check_val("s5_blue_cnt", delta(2), 0);
`else
        check_val("s5_yellow_cnt", delta(0), 1);
        check_val("s5_blue_cnt", delta(2), 1);
        check_val("s5_code", {30'd0, btn_code}, 32'd0);
`endif
        repeat (10) step(4'b0000);
        snap();
        repeat (15) step(4'b0010);
        check_val("s5_red_cnt", delta(1), 1);
        check_val("s5_red_code", {30'd0, btn_code}, 32'd1);
        repeat (10) step(4'b0000);

        // 6: three yellow press/release pairs
        snap();
        repeat (3) begin
            repeat (10) step(4'b0001);
            repeat (10) step(4'b0000);
        end
        check_val("s6_yellow_cnt", delta(0), 3);

        // reset in the middle of a count, button still pressed afterwards
        repeat (4) step(4'b0010);
        do_reset(2, 4'b0010);
        snap();
        repeat (12) step(4'b0010);
        check_val("mid_reset_red_cnt", delta(1), 1);
        repeat (10) step(4'b0000);

        // randomized button activity with occasional resets
        cur = 4'b0000;
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) cur[i] = ~cur[i];
            end
            if ($urandom_range(0, 399) == 0) do_reset(2, cur);
            else step(cur);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
